// File: rtl/instr_sequencer.sv
// Instruction fetch/execute sequencer: fetches into the IR, steps through one or two
// execute cycles and owns the status flags. Optional retired counter: INSTR_COUNT_EN.
module instr_sequencer #(
    parameter int                 INSTR_W  = 32,
    parameter logic [INSTR_W-1:0] IR_RESET = '0,
    parameter int                 CNT_W    = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    output logic               mem_req,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               stall,
    input  logic               cw_state,
    input  logic               status_load,
    input  logic [3:0]         alu_status,
    output logic [INSTR_W-1:0] instr,
    output logic               state,
    output logic               exec_valid,
    output logic               pc_advance,
    output logic [3:0]         status
`ifdef INSTR_COUNT_EN
    ,
    output logic [CNT_W-1:0]   retired_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC0 = 2'd2,
        EXEC1 = 2'd3
    } fsm_t;

    fsm_t               fsm_reg;
    fsm_t               fsm_next;
    logic [INSTR_W-1:0] ir_reg;
    logic [3:0]         status_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm_reg <= IDLE;
        end else begin
            fsm_reg <= fsm_next;
        end
    end

    always_comb begin
        fsm_next = fsm_reg;
        case (fsm_reg)
            IDLE:  fsm_next = FETCH;
            FETCH: if (mem_ack) fsm_next = EXEC0;
            EXEC0: if (!stall) fsm_next = cw_state ? EXEC1 : FETCH;
            EXEC1: if (!stall) fsm_next = FETCH;
            default: fsm_next = IDLE;
        endcase
    end

    assign mem_req    = (fsm_reg == FETCH);
    assign exec_valid = (fsm_reg == EXEC0) || (fsm_reg == EXEC1);
    assign state      = (fsm_reg == EXEC1);
    // In EXEC1 cw_state is a don't-care: a second cycle always completes the instruction.
    assign pc_advance = exec_valid & ~stall & (state | ~cw_state);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ir_reg <= IR_RESET;
        end else if (mem_req && mem_ack) begin
            ir_reg <= mem_rdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            status_reg <= 4'b0000;
        end else if (exec_valid && status_load && !stall) begin
            status_reg <= alu_status;
        end
    end

    assign instr  = ir_reg;
    assign status = status_reg;

`ifdef INSTR_COUNT_EN
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg <= '0;
        end else if (pc_advance) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign retired_cnt = cnt_reg;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: fetched words go into a scoreboard queue and are popped
// when the sequencer enters its execute phase; flags and counter tracked by a small model.
module tb_instr_sequencer;
    localparam int W  = 32;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          mem_req;
    logic          mem_ack = 1'b0;
    logic [W-1:0]  mem_rdata = '0;
    logic          stall = 1'b0;
    logic          cw_state = 1'b0;
    logic          status_load = 1'b0;
    logic [3:0]    alu_status = 4'b0000;
    logic [W-1:0]  instr;
    logic          state;
    logic          exec_valid;
    logic          pc_advance;
    logic [3:0]    status;
`ifdef INSTR_COUNT_EN
    logic [CW-1:0] retired_cnt;
`endif

    int            total = 0;
    int            bad = 0;
    logic [W-1:0]  sb[$];
    logic [3:0]    status_exp = 4'b0000;
    logic [CW-1:0] cnt_exp = '0;

    instr_sequencer #(
        .INSTR_W (W),
        .IR_RESET('0),
        .CNT_W   (CW)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .mem_req    (mem_req),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .stall      (stall),
        .cw_state   (cw_state),
        .status_load(status_load),
        .alu_status (alu_status),
        .instr      (instr),
        .state      (state),
        .exec_valid (exec_valid),
        .pc_advance (pc_advance),
        .status     (status)
`ifdef INSTR_COUNT_EN
        ,
        .retired_cnt(retired_cnt)
`endif
    );

    always #5 clock = ~clock;

    // One complete instruction: fetch (optionally with stall held high and a
    // premature status_load), optional EXEC0 stalls, optional second cycle.
    task automatic run_instr(input logic [W-1:0] word, input int ack_dly, input bit two,
                             input int stalls, input bit sl, input logic [3:0] alu,
                             input bit fstall);
        logic [W-1:0] exp;
        stall = fstall; cw_state = 1'b0; status_load = 1'b1; alu_status = ~alu;
        for (int i = 0; i < 20 && mem_req !== 1'b1; i++) begin @(negedge clock); #1; end
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL fetch_req: mem_req=%b want 1", mem_req); end
        total++; if ({exec_valid, pc_advance} !== 2'b00) begin bad++; $display("FAIL fetch_idle_out: {exec_valid,pc_advance}=%b want 00", {exec_valid, pc_advance}); end
        repeat (ack_dly) begin
            @(negedge clock); #1;
            total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL req_hold: mem_req=%b want 1", mem_req); end
        end
        mem_ack = 1'b1; mem_rdata = word; sb.push_back(word);
        @(negedge clock);
        mem_ack = 1'b0; mem_rdata = $urandom; status_load = sl; alu_status = alu;
        stall = (stalls > 0); cw_state = two;
        #1;
        exp = sb.pop_front();
        total++; if (instr !== exp) begin bad++; $display("FAIL ir_load: instr=%h want %h", instr, exp); end
        total++; if ({exec_valid, state} !== 2'b10) begin bad++; $display("FAIL exec0: {exec_valid,state}=%b want 10", {exec_valid, state}); end
        total++; if (status !== status_exp) begin bad++; $display("FAIL status_fetch: status=%b want %b", status, status_exp); end
        for (int s = 0; s < stalls; s++) begin
            total++; if (pc_advance !== 1'b0) begin bad++; $display("FAIL stall_pc: pc_advance=%b want 0", pc_advance); end
            @(negedge clock); #1;
            total++; if ({exec_valid, state, instr} !== {2'b10, exp}) begin bad++; $display("FAIL stall_hold: ev/st/ir=%b%b/%h want 10/%h", exec_valid, state, instr, exp); end
            total++; if (status !== status_exp) begin bad++; $display("FAIL stall_status: status=%b want %b", status, status_exp); end
        end
        stall = 1'b0; #1;
        total++; if (pc_advance !== !two) begin bad++; $display("FAIL exec0_pc: pc_advance=%b want %b", pc_advance, !two); end
        if (sl) status_exp = alu;
        if (!two) cnt_exp++;
        @(negedge clock);
        status_load = 1'b0; cw_state = 1'($urandom_range(1));
        #1;
        total++; if (status !== status_exp) begin bad++; $display("FAIL status_load: status=%b want %b", status, status_exp); end
        if (two) begin
            total++; if ({exec_valid, state, instr} !== {2'b11, exp}) begin bad++; $display("FAIL exec1: ev/st/ir=%b%b/%h want 11/%h", exec_valid, state, instr, exp); end
            total++; if (pc_advance !== 1'b1) begin bad++; $display("FAIL exec1_pc: pc_advance=%b want 1", pc_advance); end
            cnt_exp++;
            @(negedge clock); #1;
        end
        total++; if ({mem_req, exec_valid} !== 2'b10) begin bad++; $display("FAIL next_fetch: {mem_req,exec_valid}=%b want 10", {mem_req, exec_valid}); end
`ifdef INSTR_COUNT_EN
        total++; if (retired_cnt !== cnt_exp) begin bad++; $display("FAIL retired_cnt: got %0d want %0d", retired_cnt, cnt_exp); end
`endif
        $display("instr %h two=%0d stalls=%0d status=%b", word, two, stalls, status);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        total++; if ({mem_req, exec_valid, state, pc_advance} !== 4'b0000) begin bad++; $display("FAIL reset_ctrl: req/ev/st/pc=%b want 0000", {mem_req, exec_valid, state, pc_advance}); end
        total++; if ({instr, status} !== {W'(0), 4'b0000}) begin bad++; $display("FAIL reset_regs: instr=%h status=%b want 0/0000", instr, status); end
        reset_n = 1'b1; status_exp = 4'b0000; cnt_exp = '0;
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL idle_req: mem_req=%b want 0", mem_req); end
        @(negedge clock); #1;
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL first_req: mem_req=%b want 1", mem_req); end
        run_instr(32'h92000401, 2, 1'b0, 0, 1'b0, 4'b0000, 1'b0);
    endtask

    task automatic test_two_cycle;
        run_instr(32'hF8000000, 1, 1'b1, 0, 1'b1, 4'b0101, 1'b1);
    endtask

    task automatic test_stall;
        run_instr(32'h12345678, 0, 1'b0, 4, 1'b1, 4'b1010, 1'b0);
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 6; k++)
            run_instr($urandom, 0, k[0], k % 3, k[1], 4'($urandom), 1'b0);
        run_instr(32'hCAFE0001, 0, 1'b0, 2, 1'b1, 4'b1010, 1'b0);
    endtask

    task automatic test_stray_ack_reset;
        for (int i = 0; i < 20 && mem_req !== 1'b1; i++) begin @(negedge clock); #1; end
        mem_ack = 1'b1; mem_rdata = 32'hF8000000; sb.push_back(32'hF8000000);
        @(negedge clock);
        mem_ack = 1'b0; cw_state = 1'b1; stall = 1'b0; status_load = 1'b0;
        #1;
        total++; if (instr !== sb[0]) begin bad++; $display("FAIL stray_ir0: instr=%h want %h", instr, sb[0]); end
        @(negedge clock);
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF; stall = 1'b1;
        #1;
        total++; if (state !== 1'b1) begin bad++; $display("FAIL stray_exec1: state=%b want 1", state); end
        @(negedge clock);
        mem_ack = 1'b0;
        #1;
        total++; if (instr !== sb[0]) begin bad++; $display("FAIL stray_ack: instr=%h want %h", instr, sb[0]); end
        stall = 1'b0; #1;
        total++; if (pc_advance !== 1'b1) begin bad++; $display("FAIL pre_reset_pc: pc_advance=%b want 1", pc_advance); end
        reset_n = 1'b0; #1;
        void'(sb.pop_front());
        total++; if ({mem_req, exec_valid, state, pc_advance} !== 4'b0000) begin bad++; $display("FAIL async_reset_ctrl: req/ev/st/pc=%b want 0000", {mem_req, exec_valid, state, pc_advance}); end
        total++; if ({instr, status} !== {W'(0), 4'b0000}) begin bad++; $display("FAIL async_reset_regs: instr=%h status=%b want 0/0000", instr, status); end
        $display("stray ack + async reset in EXEC1");
        repeat (2) @(negedge clock);
        reset_n = 1'b1; status_exp = 4'b0000; cnt_exp = '0;
    endtask

`ifdef INSTR_COUNT_EN
    task automatic test_counter;
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1; status_exp = 4'b0000; cnt_exp = '0;
        for (int k = 0; k < 17; k++) run_instr($urandom, 0, 1'b0, 0, 1'b0, 4'b0000, 1'b0);
        total++; if (retired_cnt !== 4'd1) begin bad++; $display("FAIL cnt_wrap: retired_cnt=%0d want 1", retired_cnt); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_two_cycle();
        test_back_to_back();
        test_stall();
        test_stray_ack_reset();
`ifdef INSTR_COUNT_EN
        test_counter();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Upstream stage of the control unit.
- Fetches a 32-bit instruction via a req/ack handshake and holds it in the instruction register (IR).
- Presents the IR and the execute-phase bit (state) to the instruction decoders, which produce the 94-bit control word.
- Sequences single- and two-cycle instructions, owns the 4-bit status register (V,C,N,Z) and tells the PC logic when an instruction completes.

Parameters:
- INSTR_W, 32, instruction/IR width.
- IR_RESET, 0, IR value after reset.
- CNT_W, 32, retired-instruction counter width (optional feature only).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- mem_req  out  1  fetch request to instruction memory.
- mem_ack  in  1  memory: mem_rdata valid this cycle.
- mem_rdata  in  INSTR_W  fetched instruction word.
- stall  in  1  freezes the execute phase.
- cw_state  in  1  next-state bit from the decoder control word.
- status_load  in  1  control-word status load enable.
- alu_status  in  4  ALU flags {V,C,N,Z}.
- instr  out  INSTR_W  IR contents, drives the decoders.
- state  out  1  execute phase: 0 = first cycle, 1 = second cycle.
- exec_valid  out  1  high in execute cycles; datapath write enables are gated by it.
- pc_advance  out  1  one-cycle pulse on instruction completion.
- status  out  4  status register {V,C,N,Z}.
- retired_cnt  out  CNT_W  only with INSTR_COUNT_EN.

Behaviour:
- FSM states: IDLE, FETCH, EXEC0, EXEC1. All registers are reset asynchronously while reset_n = 0.
- Reset values:
  - FSM = IDLE, IR = IR_RESET, status = 0.
  - mem_req = 0, exec_valid = 0, state = 0, pc_advance = 0.
- Output decode from the FSM register:
  - mem_req = (FSM == FETCH).
  - exec_valid = (FSM is EXEC0 or EXEC1).
  - state = (FSM == EXEC1).
- IDLE: go to FETCH unconditionally on the next edge. IDLE is entered only via reset.
- FETCH:
  - mem_req stays high until mem_ack.
  - On mem_ack: IR <= mem_rdata and FSM -> EXEC0 at the same edge.
  - No ack: stay in FETCH; the wait is unbounded.
- mem_ack outside FETCH is ignored; IR is unchanged.
- EXEC0:
  - stall = 1: hold state, IR and status; no pc_advance.
  - stall = 0 and cw_state = 1: go to EXEC1; no pc_advance.
  - stall = 0 and cw_state = 0: go to FETCH; pc_advance = 1 this cycle.
- EXEC1:
  - stall = 1: hold.
  - stall = 0: go to FETCH with pc_advance = 1.
  - cw_state is ignored in EXEC1; instructions are at most 2 execute cycles.
- pc_advance = exec_valid & ~stall & (state | ~cw_state). It is combinational and high for exactly one cycle per instruction.
- Status register: status <= alu_status on an edge where exec_valid & status_load & ~stall. Otherwise it holds. It is never cleared except by reset.
- Latency:
  - mem_ack edge to first execute cycle: 1 clock.
  - Best-case throughput: 1-cycle instruction every 2 clocks; 2-cycle instruction every 3 clocks.
- IR is stable for the whole execute phase, including stalls. It changes only on an accepted fetch.
- Reset mid-operation (any state): immediate return to the reset values. A pending fetch is abandoned; memory must drop any ack in flight.
- stall asserted in FETCH or IDLE has no effect.

Optional Feature:
- Macro: INSTR_COUNT_EN.
- Defined:
  - retired_cnt is a CNT_W-bit counter that resets to 0.
  - It increments on every edge where pc_advance = 1.
  - It wraps from all-ones to 0 with no flag.
- Undefined:
  - retired_cnt port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset and single-cycle fetch:
  - Stimulus: reset_n low 3 cycles, release; mem_ack after 2 cycles with mem_rdata = 32'h92000401 (ANDI); cw_state = 0.
  - Required: mem_req rises 1 cycle after release; instr = 32'h92000401, state = 0, exec_valid = 1 for 1 cycle with pc_advance = 1; then mem_req = 1 again.
- Two-cycle instruction:
  - Stimulus: fetch 32'hF8000000 with cw_state = 1 in EXEC0.
  - Required: state = 0 then 1; pc_advance only in the state = 1 cycle; 3 clocks from ack to next mem_req.
- Stall:
  - Stimulus: stall = 1 for 4 cycles in EXEC0 with status_load = 1, alu_status = 4'b1010.
  - Required: FSM, IR and status unchanged during the stall; status = 4'b1010 after the first unstalled edge.
- Stray ack and reset mid-execute:
  - Stimulus: mem_ack pulsed in EXEC1 with mem_rdata = 32'hFFFFFFFF; then reset_n low asynchronously mid-EXEC1.
  - Required: IR is not overwritten by the stray ack; on reset all outputs return to reset values immediately, without waiting for a clock edge.
- Counter (INSTR_COUNT_EN defined, CNT_W = 4):
  - Stimulus: 17 back-to-back 1-cycle instructions.
  - Required: retired_cnt = 1 after the 17th (wrap at 16).
